// File: rtl/buma_decode_serial_pkg.sv
// Shared constants for the complement-code datapath (decode side and adder).
// Latency: n/a (constants only).
// Backpressure: n/a.
package buma_decode_serial_pkg;

    // Default word width, shared with the complement adder.
    localparam int WORD_W = 32;

    // Controller state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/buma_decode_serial_if.sv
// Handshake bundle for the serial two's-complement -> sign-magnitude decoder.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the input word, out_valid/out_ready on the result.
// Ports: in_valid, I (word in), in_ready; out_valid, O, overflow (result), out_ready; busy.
// master drives the word and consumes the result; slave is the converter.
interface buma_decode_serial_if #(
    parameter int WIDTH = buma_decode_serial_pkg::WORD_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] I;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] O;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, I, out_ready,
        input  in_ready, out_valid, O, overflow, busy
    );

    modport slave (
        input  in_valid, I, out_ready,
        output in_ready, out_valid, O, overflow, busy
    );
endinterface

// File: rtl/buma_decode_serial_neg_bit_cell.sv
// One bit of serial two's-complement negation (copy up to first 1, invert above).
// Latency: combinational.
// Backpressure: none; the caller sequences bits.
// Ports: b (current bit, LSB first), sign (negate enable), seen_one (a 1 has passed)
//        -> outbit (negated or passed-through bit), seen_one_next.
module neg_bit_cell (
    input  logic b,
    input  logic sign,
    input  logic seen_one,
    output logic outbit,
    output logic seen_one_next
);
    // Positive words pass straight through so timing is data independent.
    assign outbit        = (sign && seen_one) ? ~b : b;
    assign seen_one_next = seen_one | b;
endmodule

// File: rtl/buma_decode_serial.sv
// Bit-serial two's-complement to sign-magnitude converter with most-negative overflow flag.
// Latency: accept at edge k, out_valid high after edge k+WIDTH-1; one word per WIDTH+1 cycles max.
// Backpressure: result held in DONE until out_ready; in_ready low whenever not IDLE.
// Ports: clk, reset (async, active-high), bus (slave side of buma_decode_serial_if).
module buma_decode_serial
    import buma_decode_serial_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic                clk,
    input  logic                reset,
    buma_decode_serial_if.slave bus
);
    // Counter only needs to reach WIDTH-2 (index of the last magnitude bit).
    localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 2);

    logic [1:0]       state;
    logic [WIDTH-2:0] sr;
    logic [WIDTH-2:0] mag;
    logic [WIDTH-2:0] mag_next;
    logic [CNT_W-1:0] cnt;
    logic             sign;
    logic             seen_one;
    logic             outbit;
    logic             seen_one_next;

    neg_bit_cell u_cell (
        .b             (sr[0]),
        .sign          (sign),
        .seen_one      (seen_one),
        .outbit        (outbit),
        .seen_one_next (seen_one_next)
    );

    // Magnitude fills from the top so that after WIDTH-1 shifts bit 0 is the LSB.
    generate
        if (WIDTH > 2) begin : g_mag_wide
            assign mag_next = {outbit, mag[WIDTH-2:1]};
        end else begin : g_mag_one
            assign mag_next = outbit;
        end
    endgenerate

    assign bus.in_ready  = (state == ST_IDLE) && !reset;
    assign bus.busy      = (state == ST_SHIFT);
    assign bus.out_valid = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            sr           <= '0;
            mag          <= '0;
            cnt          <= '0;
            sign         <= 1'b0;
            seen_one     <= 1'b0;
            bus.O        <= '0;
            bus.overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        sr       <= bus.I[WIDTH-2:0];
                        sign     <= bus.I[WIDTH-1];
                        seen_one <= 1'b0;
                        cnt      <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sr       <= sr >> 1;
                    mag      <= mag_next;
                    seen_one <= seen_one_next;
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        bus.O        <= {sign, mag_next};
                        // Negative with no 1 anywhere below the sign: 100..0 has no magnitude.
                        bus.overflow <= sign & ~seen_one_next;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_buma_decode_serial.sv
// Scoreboard bench for buma_decode_serial: stimulus pushes model results, a monitor pops on each handshake.
// Latency: checks accept-to-out_valid distance and result spacing.
// Backpressure: directed stall plus randomized out_ready.
module tb_buma_decode_serial;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] o;
        logic         ov;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    buma_decode_serial_if #(.WIDTH(W)) bus ();

    buma_decode_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t q[$];
    int   total     = 0;
    int   bad       = 0;
    int   cyc       = 0;
    int   acc_cyc   = 0;
    int   prev_rise = -1;
    logic prev_ov   = 1'b0;
    bit   rand_rdy  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: sign-magnitude from signed arithmetic value.
    function automatic exp_t model(input logic [W-1:0] w);
        exp_t          e;
        longint signed v;
        v = longint'($signed(w));
        if (v == -(longint'(1) <<< (W - 1))) begin
            e.o  = {1'b1, {(W-1){1'b0}}};
            e.ov = 1'b1;
        end else if (v < 0) begin
            e.o  = {1'b1, (W-1)'(-v)};
            e.ov = 1'b0;
        end else begin
            e.o  = w;
            e.ov = 1'b0;
        end
        return e;
    endfunction

    task automatic send(input logic [W-1:0] w, input bit push);
        int n;
        n = 0;
        bus.I        = w;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready %b want 1 for word %h", bus.in_ready, w);
        end else if (push) begin
            q.push_back(model(w));
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.I        = $urandom;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !bus.in_ready) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0 || !bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending %0d want 0", q.size());
        end
    endtask

    // Monitor: protocol checks and scoreboard pops, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.busy) chk("in_ready_while_busy", W'(bus.in_ready), W'(0));
                if (bus.out_valid && !prev_ov) begin
                    chk("latency", W'(cyc - acc_cyc), W'(W - 1));
                    if (prev_rise >= 0) chk("spacing_ge_w_plus_1", W'(cyc - prev_rise >= W + 1), W'(1));
                    prev_rise = cyc;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: got %h want none", bus.O);
                    end else begin
                        e = q.pop_front();
                        chk("O", bus.O, e.o);
                        chk("overflow", W'(bus.overflow), W'(e.ov));
                    end
                end
            end
            prev_ov = reset ? 1'b0 : bus.out_valid;
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        bad++;
        $display("FAIL watchdog: cycles %0d want < 20000", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   n;
        logic [W-1:0] w;

        bus.in_valid  = 1'b0;
        bus.I         = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_O", bus.O, W'(0));
        chk("rst_overflow", W'(bus.overflow), W'(0));
        chk("rst_out_valid", W'(bus.out_valid), W'(0));
        chk("rst_busy", W'(bus.busy), W'(0));
        chk("rst_in_ready", W'(bus.in_ready), W'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        // Directed words.
        send(32'h0000_0005, 1'b1); idle(); wait_drain();
        send(32'hFFFF_FFFB, 1'b1); idle();
        send(32'hFFFF_FFFF, 1'b1); idle();
        send(32'h8000_0000, 1'b1); idle();
        send(32'h8000_0001, 1'b1); idle();
        send(32'h0000_0000, 1'b1); idle();
        wait_drain();

        // Backpressure in DONE with in_valid toggling.
        bus.out_ready = 1'b0;
        w = 32'hC000_0003;
        send(w, 1'b1); idle();
        e = model(w);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", W'(bus.out_valid), W'(1));
            chk("bp_O", bus.O, e.o);
            chk("bp_overflow", W'(bus.overflow), W'(e.ov));
            chk("bp_in_ready", W'(bus.in_ready), W'(0));
            bus.in_valid = ~bus.in_valid;
            bus.I        = $urandom;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", W'(bus.out_valid), W'(0));
        chk("bp_release_in_ready", W'(bus.in_ready), W'(1));
        chk("bp_release_busy", W'(bus.busy), W'(0));
        wait_drain();

        // Reset in the middle of SHIFT discards the word.
        send(32'h0BAD_F00D, 1'b0); idle();
        repeat (15) @(posedge clk);
        #1;
        chk("mid_busy_before_reset", W'(bus.busy), W'(1));
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", W'(bus.busy), W'(0));
        chk("mid_rst_out_valid", W'(bus.out_valid), W'(0));
        chk("mid_rst_in_ready", W'(bus.in_ready), W'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
        chk("post_rst_out_valid", W'(bus.out_valid), W'(0));
        chk("post_rst_in_ready", W'(bus.in_ready), W'(1));
        send(32'hFFFF_FF9C, 1'b1); idle(); wait_drain();

        // Back-to-back with in_valid held high.
        send(32'h0000_0000, 1'b1);
        send(32'h7FFF_FFFF, 1'b1);
        send(32'h8000_0000, 1'b1);
        idle();
        wait_drain();

        // Randomized words with random consumer stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 4))
                0: w = $urandom;
                1: w = -W'($urandom_range(1, 300));
                2: w = 32'h8000_0000;
                3: w = W'($urandom_range(0, 300));
                default: w = $urandom | 32'h8000_0000;
            endcase
            send(w, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                idle();
                repeat ($urandom_range(0, 5)) @(posedge clk);
                #1;
            end
        end
        idle();
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        wait_drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
